hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage RISC-V core. It generates per-stage register write enables, flush and bubble controls from decode/execute hazard information and the data-memory handshake. It covers the cases that operand forwarding alone cannot resolve: load-use stalls, taken-branch redirect flushes, data-memory wait freezes, and a memory-timeout halt. It sits beside the forwarding unit, and its enables drive the FD/DE/EM/MW pipeline registers and the PC.

## Interface
- MEM_TIMEOUT, 255: consecutive data-memory wait cycles before halting; 0 disables the timeout.
- CNT_W, 16: width of the stall performance counter.

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- FD_RS1, FD_RS2  in  5 each  source registers of the instruction in decode
- FD_USE_RS1, FD_USE_RS2  in  1 each  decode instruction actually reads RS1 / RS2
- DE_RD  in  5  destination register of the instruction in execute
- DE_M2R, DE_REGWRT  in  1 each  execute instruction is a load / writes a register
- DE_BRANCH_TAKEN  in  1  execute instruction redirects the PC (taken branch, JAL, JALR)
- EM_MEM_REQ  in  1  memory-stage instruction accesses data memory
- DMEM_ACK  in  1  data memory completes the access this cycle
- PC_WRT, FD_WRT, DE_WRT, EM_WRT, MW_WRT  out  1 each  PC / pipeline register write enables
- FD_FLUSH, DE_FLUSH  out  1 each  load NOP into FD / DE on this edge (effective only with the matching WRT=1)
- MW_BUBBLE  out  1  load NOP into MW (valid with MW_WRT=1)
- MEM_ERR  out  1  sticky timeout error
- STATE  out  2  RUN=0, REDIRECT=1, HALT=2
- STALL_CNT  out  CNT_W  saturating count of cycles with PC_WRT=0 outside reset

## Operation
- Registered state: FSM (RUN / REDIRECT / HALT), wait counter (width fits MEM_TIMEOUT), MEM_ERR, STALL_CNT. All control outputs are combinational from state and inputs.
- Definitions:
  - freeze = EM_MEM_REQ & ~DMEM_ACK.
  - loaduse = DE_M2R & DE_REGWRT & (DE_RD != 0) & ((FD_USE_RS1 & FD_RS1 == DE_RD) | (FD_USE_RS2 & FD_RS2 == DE_RD)).
- Cycle priority, highest first: RST > HALT > freeze > branch (RUN only) > REDIRECT > loaduse (RUN only) > normal.
  - RST=1: all WRT=0, FD_FLUSH=DE_FLUSH=MW_BUBBLE=1.
  - HALT: all WRT=0, all flush/bubble=0. Stays in HALT until RST.
  - freeze: PC/FD/DE/EM_WRT=0, MW_WRT=1, MW_BUBBLE=1. State is unchanged, including REDIRECT.
  - branch (state RUN, DE_BRANCH_TAKEN=1, no freeze): all WRT=1, FD_FLUSH=DE_FLUSH=1. Next state REDIRECT.
  - REDIRECT (no freeze): all WRT=1, FD_FLUSH=1, DE_FLUSH=0. Next state RUN. DE_BRANCH_TAKEN and loaduse are ignored (DE holds a bubble; IMEM is synchronous, so the wrong-path fetch is discarded).
  - loaduse: PC_WRT=FD_WRT=0, DE_WRT=1, DE_FLUSH=1, EM_WRT=MW_WRT=1. State stays RUN. The next cycle re-evaluates with the load in EM, where the forwarding unit supplies R_DATA.
  - normal: all WRT=1, flush/bubble=0.
- Wait counter:
  - Increments on every freeze cycle; clears on any non-freeze cycle.
  - If MEM_TIMEOUT != 0 and a freeze cycle occurs with counter == MEM_TIMEOUT-1: next state HALT, MEM_ERR set to 1.
- STALL_CNT: +1 on every non-reset cycle with PC_WRT=0 (loaduse, freeze, HALT). Saturates at all-ones.

## Timing
- Reset values: STATE=RUN, MEM_ERR=0, wait counter=0, STALL_CNT=0. After the RST-low edge, outputs follow the normal rules from the first cycle.
- Zero-latency control: outputs respond to inputs in the same cycle.
- Branch sequence is exactly two flush cycles: the branch cycle flushes FD and DE, the REDIRECT cycle flushes FD.
- Freeze holds the whole pipeline for any duration. DE_BRANCH_TAKEN remains stable while frozen and is acted on in the first cycle with DMEM_ACK=1.
- DMEM_ACK=1 while EM_MEM_REQ=1 counts as no freeze. EM_MEM_REQ=0 never freezes, whatever DMEM_ACK is.
- Timeout boundary: with MEM_TIMEOUT=N, the N-th consecutive freeze cycle is the last non-HALT cycle. HALT begins at the next edge.
- Reset mid-operation (any state, any freeze or counter value): one RST cycle returns all registers to reset values.
- DE_RD=0 never causes a loaduse stall.

## Test plan
- Load-use: DE_M2R=1, DE_REGWRT=1, DE_RD=5, FD_RS1=5, FD_USE_RS1=1 -> that cycle PC_WRT=0, FD_WRT=0, DE_FLUSH=1, STALL_CNT 0->1. Next cycle (DE_M2R=0) all WRT=1.
- Branch: DE_BRANCH_TAKEN=1 in RUN, with a simultaneous loaduse condition -> cycle 1 FD_FLUSH=DE_FLUSH=1, PC_WRT=1. Cycle 2 STATE=1, FD_FLUSH=1, DE_FLUSH=0. Cycle 3 STATE=0. STALL_CNT unchanged.
- Memory wait: EM_MEM_REQ=1, DMEM_ACK=0 for 3 cycles, then ACK=1 -> 3 cycles of PC/FD/DE/EM_WRT=0 with MW_BUBBLE=1, STALL_CNT=3, then all WRT=1.
- Freeze during REDIRECT: branch, then freeze for 2 cycles -> STATE stays 1 through the freeze; FD_FLUSH=1 in the first unfrozen cycle, then STATE=0.
- Timeout: MEM_TIMEOUT=4, freeze held -> cycles 1-4 freeze outputs; cycle 5 STATE=2, MEM_ERR=1, all WRT=0. Assert RST for 1 cycle -> STATE=0, MEM_ERR=0, STALL_CNT=0.
- Saturation and x0: CNT_W=4, hold HALT for 20 cycles -> STALL_CNT stops at 15. Loaduse pattern with DE_RD=0 -> no stall.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline sequencing controller for a 5-stage RISC-V core. It turns
// decode/execute hazard information and the data-memory handshake into
// PC / pipeline-register write enables plus flush and bubble controls.
// It handles load-use stalls, taken-branch redirect flushes, data-memory
// wait freezes and a memory-timeout halt.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fd_rs1/fd_rs2            decode source registers
//   fd_use_rs1/fd_use_rs2    decode instruction reads rs1 / rs2
//   de_rd, de_m2r, de_regwrt execute destination, is-load, writes-register
//   de_branch_taken          execute instruction redirects the PC
//   em_mem_req, dmem_ack     memory-stage access request and completion
//   pc_wrt..mw_wrt           PC / FD / DE / EM / MW write enables
//   fd_flush, de_flush       load NOP into FD / DE (with matching write enable)
//   mw_bubble                load NOP into MW (with mw_wrt)
//   mem_err                  sticky memory-timeout error
//   state                    RUN=0, REDIRECT=1, HALT=2
//   stall_cnt                saturating count of cycles with pc_wrt=0
module hazard_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       fd_rs1,
  input  logic [4:0]       fd_rs2,
  input  logic             fd_use_rs1,
  input  logic             fd_use_rs2,
  input  logic [4:0]       de_rd,
  input  logic             de_m2r,
  input  logic             de_regwrt,
  input  logic             de_branch_taken,
  input  logic             em_mem_req,
  input  logic             dmem_ack,
  output logic             pc_wrt,
  output logic             fd_wrt,
  output logic             de_wrt,
  output logic             em_wrt,
  output logic             mw_wrt,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             mw_bubble,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic                mem_err_r;
  logic [CNT_W-1:0]    stall_cnt_r;

  logic freeze_s;
  logic freeze_eff_s;
  logic loaduse_s;
  logic timeout_hit_s;

  assign freeze_s = em_mem_req & ~dmem_ack;

  // HALT outranks a freeze, so a stalled access seen while halted is not a freeze cycle.
  assign freeze_eff_s = freeze_s & (state_r != ST_HALT);

  assign loaduse_s = de_m2r & de_regwrt & (de_rd != 5'd0) &
                     ((fd_use_rs1 & (fd_rs1 == de_rd)) |
                      (fd_use_rs2 & (fd_rs2 == de_rd)));

  // The freeze cycle that finds the counter at N-1 is the N-th consecutive one.
  assign timeout_hit_s = (MEM_TIMEOUT != 0) && freeze_eff_s &&
                         (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: freeze holds the state (REDIRECT included) unless it times out.
  always_comb begin
    state_nxt_s = ST_RUN;
    case (state_r)
      ST_RUN: begin
        if (freeze_s) begin
          state_nxt_s = timeout_hit_s ? ST_HALT : ST_RUN;
        end else if (de_branch_taken) begin
          state_nxt_s = ST_REDIRECT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (freeze_s) begin
          state_nxt_s = timeout_hit_s ? ST_HALT : ST_REDIRECT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Output logic: zero-latency controls in priority order reset > halt > freeze > branch > redirect > load-use.
  always_comb begin
    pc_wrt    = 1'b1;
    fd_wrt    = 1'b1;
    de_wrt    = 1'b1;
    em_wrt    = 1'b1;
    mw_wrt    = 1'b1;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    mw_bubble = 1'b0;
    if (rst) begin
      pc_wrt    = 1'b0;
      fd_wrt    = 1'b0;
      de_wrt    = 1'b0;
      em_wrt    = 1'b0;
      mw_wrt    = 1'b0;
      fd_flush  = 1'b1;
      de_flush  = 1'b1;
      mw_bubble = 1'b1;
    end else if (state_r == ST_HALT) begin
      pc_wrt = 1'b0;
      fd_wrt = 1'b0;
      de_wrt = 1'b0;
      em_wrt = 1'b0;
      mw_wrt = 1'b0;
    end else if (freeze_s) begin
      // Upstream stages hold; MW drains a bubble so the stalled access is not retired twice.
      pc_wrt    = 1'b0;
      fd_wrt    = 1'b0;
      de_wrt    = 1'b0;
      em_wrt    = 1'b0;
      mw_bubble = 1'b1;
    end else if ((state_r == ST_RUN) && de_branch_taken) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (state_r == ST_REDIRECT) begin
      // DE already holds a bubble; only the wrong-path fetch in FD is discarded.
      fd_flush = 1'b1;
    end else if ((state_r == ST_RUN) && loaduse_s) begin
      pc_wrt   = 1'b0;
      fd_wrt   = 1'b0;
      de_flush = 1'b1;
    end else begin
      pc_wrt = 1'b1;
    end
  end

  // Wait counter, sticky timeout error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r  <= {WAIT_W{1'b0}};
      mem_err_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (freeze_eff_s) begin
        if (wait_cnt_r != {WAIT_W{1'b1}}) begin
          wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
          wait_cnt_r <= wait_cnt_r;
        end
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
      if (timeout_hit_s) begin
        mem_err_r <= 1'b1;
      end else begin
        mem_err_r <= mem_err_r;
      end
      if (!pc_wrt && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign mem_err   = mem_err_r;
  assign state     = state_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller. One instance uses
// MEM_TIMEOUT=4 / CNT_W=4 (timeout and saturation), a second uses the
// defaults and shares the same inputs.
module tb_hazard_controller;

  logic       clk;
  logic       rst;
  logic [4:0] fd_rs1, fd_rs2, de_rd;
  logic       fd_use_rs1, fd_use_rs2, de_m2r, de_regwrt, de_branch_taken;
  logic       em_mem_req, dmem_ack;

  logic       pc_wrt, fd_wrt, de_wrt, em_wrt, mw_wrt, fd_flush, de_flush, mw_bubble, mem_err;
  logic [1:0] state;
  logic [3:0] stall_cnt;

  logic        d_pc_wrt, d_fd_wrt, d_de_wrt, d_em_wrt, d_mw_wrt, d_fd_flush, d_de_flush, d_mw_bubble, d_mem_err;
  logic [1:0]  d_state;
  logic [15:0] d_stall_cnt;

  int n_cmp;
  int n_fail;

  // {pc, fd, de, em, mw, fd_flush, de_flush, mw_bubble}
  localparam logic [7:0] C_NORM  = 8'b11111_000;
  localparam logic [7:0] C_LU    = 8'b00111_010;
  localparam logic [7:0] C_FRZ   = 8'b00001_001;
  localparam logic [7:0] C_BR    = 8'b11111_110;
  localparam logic [7:0] C_REDIR = 8'b11111_100;
  localparam logic [7:0] C_HALT  = 8'b00000_000;
  localparam logic [7:0] C_RST   = 8'b00000_111;

  logic [7:0] ctrl, d_ctrl;
  assign ctrl   = {pc_wrt, fd_wrt, de_wrt, em_wrt, mw_wrt, fd_flush, de_flush, mw_bubble};
  assign d_ctrl = {d_pc_wrt, d_fd_wrt, d_de_wrt, d_em_wrt, d_mw_wrt, d_fd_flush, d_de_flush, d_mw_bubble};

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_use_rs1(fd_use_rs1), .fd_use_rs2(fd_use_rs2),
    .de_rd(de_rd), .de_m2r(de_m2r), .de_regwrt(de_regwrt), .de_branch_taken(de_branch_taken),
    .em_mem_req(em_mem_req), .dmem_ack(dmem_ack),
    .pc_wrt(pc_wrt), .fd_wrt(fd_wrt), .de_wrt(de_wrt), .em_wrt(em_wrt), .mw_wrt(mw_wrt),
    .fd_flush(fd_flush), .de_flush(de_flush), .mw_bubble(mw_bubble),
    .mem_err(mem_err), .state(state), .stall_cnt(stall_cnt)
  );

  hazard_controller u_dflt (
    .clk(clk), .rst(rst),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_use_rs1(fd_use_rs1), .fd_use_rs2(fd_use_rs2),
    .de_rd(de_rd), .de_m2r(de_m2r), .de_regwrt(de_regwrt), .de_branch_taken(de_branch_taken),
    .em_mem_req(em_mem_req), .dmem_ack(dmem_ack),
    .pc_wrt(d_pc_wrt), .fd_wrt(d_fd_wrt), .de_wrt(d_de_wrt), .em_wrt(d_em_wrt), .mw_wrt(d_mw_wrt),
    .fd_flush(d_fd_flush), .de_flush(d_de_flush), .mw_bubble(d_mw_bubble),
    .mem_err(d_mem_err), .state(d_state), .stall_cnt(d_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    fd_rs1 = 5'd0; fd_rs2 = 5'd0; fd_use_rs1 = 1'b0; fd_use_rs2 = 1'b0;
    de_rd = 5'd0; de_m2r = 1'b0; de_regwrt = 1'b0; de_branch_taken = 1'b0;
    em_mem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  // Inputs are applied 1 time unit after a rising edge; combinational
  // outputs are sampled on the falling edge, registers after the next edge.
  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    to_next();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    clr_inputs();
    rst = 1'b1;
    #1;

    // Reset cycle.
    to_negedge();
    chk("rst_ctrl", 32'(ctrl), 32'(C_RST));
    to_next();
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);

    // Normal operation.
    to_negedge();
    chk("normal_ctrl", 32'(ctrl), 32'(C_NORM));
    to_next();

    // Load-use on rs1.
    de_m2r = 1'b1; de_regwrt = 1'b1; de_rd = 5'd5; fd_rs1 = 5'd5; fd_use_rs1 = 1'b1;
    to_negedge();
    chk("lu_rs1_ctrl", 32'(ctrl), 32'(C_LU));
    to_next();
    chk("lu_rs1_stall", 32'(stall_cnt), 32'd1);
    chk("lu_rs1_state", 32'(state), 32'd0);
    de_m2r = 1'b0;
    to_negedge();
    chk("lu_after_ctrl", 32'(ctrl), 32'(C_NORM));
    to_next();
    chk("lu_after_stall", 32'(stall_cnt), 32'd1);

    // Load-use on rs2; then the same match without the read flag.
    clr_inputs();
    de_m2r = 1'b1; de_regwrt = 1'b1; de_rd = 5'd7; fd_rs2 = 5'd7; fd_use_rs2 = 1'b1; fd_rs1 = 5'd5;
    to_negedge();
    chk("lu_rs2_ctrl", 32'(ctrl), 32'(C_LU));
    to_next();
    fd_use_rs2 = 1'b0;
    to_negedge();
    chk("lu_nouse_ctrl", 32'(ctrl), 32'(C_NORM));
    to_next();
    chk("lu_rs2_stall", 32'(stall_cnt), 32'd2);

    // Branch with a simultaneous load-use condition.
    clr_inputs();
    de_m2r = 1'b1; de_regwrt = 1'b1; de_rd = 5'd5; fd_rs1 = 5'd5; fd_use_rs1 = 1'b1;
    de_branch_taken = 1'b1;
    to_negedge();
    chk("br_c1_ctrl", 32'(ctrl), 32'(C_BR));
    to_next();
    chk("br_c2_state", 32'(state), 32'd1);
    to_negedge();
    chk("br_c2_ctrl", 32'(ctrl), 32'(C_REDIR));
    to_next();
    chk("br_c3_state", 32'(state), 32'd0);
    chk("br_stall", 32'(stall_cnt), 32'd2);

    // Memory wait: three freeze cycles, then the acknowledge.
    clr_inputs();
    do_reset();
    chk("mw_rst_stall", 32'(stall_cnt), 32'd0);
    em_mem_req = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_negedge();
      chk("mw_frz_ctrl", 32'(ctrl), 32'(C_FRZ));
      to_next();
    end
    chk("mw_stall", 32'(stall_cnt), 32'd3);
    dmem_ack = 1'b1;
    to_negedge();
    chk("mw_ack_ctrl", 32'(ctrl), 32'(C_NORM));
    to_next();
    em_mem_req = 1'b0; dmem_ack = 1'b0;
    to_negedge();
    chk("noreq_ctrl", 32'(ctrl), 32'(C_NORM));
    to_next();
    chk("mw_stall_hold", 32'(stall_cnt), 32'd3);

    // Freeze during REDIRECT.
    de_branch_taken = 1'b1;
    to_negedge();
    chk("fr_br_ctrl", 32'(ctrl), 32'(C_BR));
    to_next();
    em_mem_req = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      to_negedge();
      chk("fr_redir_frz_ctrl", 32'(ctrl), 32'(C_FRZ));
      to_next();
      chk("fr_redir_state", 32'(state), 32'd1);
    end
    dmem_ack = 1'b1;
    to_negedge();
    chk("fr_redir_ack_ctrl", 32'(ctrl), 32'(C_REDIR));
    to_next();
    chk("fr_redir_done_state", 32'(state), 32'd0);

    // Branch held while frozen in RUN is taken on the acknowledge cycle.
    dmem_ack = 1'b0;
    to_negedge();
    chk("fr_run_frz_ctrl", 32'(ctrl), 32'(C_FRZ));
    to_next();
    chk("fr_run_state", 32'(state), 32'd0);
    dmem_ack = 1'b1;
    to_negedge();
    chk("fr_run_ack_ctrl", 32'(ctrl), 32'(C_BR));
    to_next();
    chk("fr_run_redir_state", 32'(state), 32'd1);
    clr_inputs();
    to_negedge();
    chk("fr_run_redir_ctrl", 32'(ctrl), 32'(C_REDIR));
    to_next();
    chk("fr_stall", 32'(stall_cnt), 32'd6);

    // Timeout with MEM_TIMEOUT=4.
    do_reset();
    em_mem_req = 1'b1; dmem_ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      to_negedge();
      chk("to_frz_ctrl", 32'(ctrl), 32'(C_FRZ));
      to_next();
      chk("to_state", 32'(state), (i < 4) ? 32'd0 : 32'd2);
    end
    chk("to_err", 32'(mem_err), 32'd1);
    for (int i = 0; i < 20; i++) begin
      to_negedge();
      chk("halt_ctrl", 32'(ctrl), 32'(C_HALT));
      if (i == 0) begin
        chk("dflt_frz_ctrl", 32'(d_ctrl), 32'(C_FRZ));
      end
      to_next();
      if (i == 0) begin
        chk("halt_stall_5", 32'(stall_cnt), 32'd5);
      end
    end
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    chk("halt_state", 32'(state), 32'd2);
    chk("dflt_state", 32'(d_state), 32'd0);
    chk("dflt_err", 32'(d_mem_err), 32'd0);
    chk("dflt_stall", 32'(d_stall_cnt), 32'd24);

    // HALT ignores acknowledge and branch.
    dmem_ack = 1'b1; de_branch_taken = 1'b1;
    to_negedge();
    chk("halt_ign_ctrl", 32'(ctrl), 32'(C_HALT));
    chk("dflt_br_ctrl", 32'(d_ctrl), 32'(C_BR));
    to_next();
    chk("halt_ign_state", 32'(state), 32'd2);
    chk("halt_ign_stall", 32'(stall_cnt), 32'd15);

    // One reset cycle out of HALT.
    clr_inputs();
    rst = 1'b1;
    to_negedge();
    chk("halt_rst_ctrl", 32'(ctrl), 32'(C_RST));
    to_next();
    rst = 1'b0;
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_err", 32'(mem_err), 32'd0);
    chk("halt_rst_stall", 32'(stall_cnt), 32'd0);

    // x0 destination never stalls.
    de_m2r = 1'b1; de_regwrt = 1'b1; de_rd = 5'd0; fd_rs1 = 5'd0; fd_use_rs1 = 1'b1;
    fd_rs2 = 5'd0; fd_use_rs2 = 1'b1;
    to_negedge();
    chk("x0_ctrl", 32'(ctrl), 32'(C_NORM));
    to_next();
    chk("x0_stall", 32'(stall_cnt), 32'd0);

    // A load that does not write a register never stalls.
    de_regwrt = 1'b0; de_rd = 5'd3; fd_rs1 = 5'd3;
    to_negedge();
    chk("noregwrt_ctrl", 32'(ctrl), 32'(C_NORM));
    to_next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time bound reached");
    $fatal(1, "time bound reached");
  end

endmodule
